// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, receiver state type and baud-rate helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clocks per oversampling tick; never returns less than one.
    function automatic int bddiv(input int clk, input int baud, input int ovs);
        int d;
        d = clk / (baud * ovs);
        return (d < 1) ? 1 : d;
    endfunction

    // Default oversampling for a 115200 baud link; falls back to 8 on slow clocks.
    function automatic int ovsamp(input int clk);
        return (clk >= 16 * 115200) ? 16 : 8;
    endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Free-running oversampling tick generator: one-cycle pulse every bddiv() clocks.
// Shared by the UART receiver and transmitter.
module uart_baudgen
    import uart_pkg::*;
#(
    parameter int CLK_RATE     = 100 * 10**6,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic CLK_I,
    input  logic RST_I,
    output logic TICK_O
);

    localparam int DIV = bddiv(CLK_RATE, BAUD_RATE, OVERSAMPLING);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign TICK_O = tick_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, oversampled with mid-bit sampling.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE     = 100 * 10**6,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      RX_I,
    output logic [UART_DATA_BITS-1:0] DATA_O,
    output logic                      RX_DONE_O,
    output logic                      RX_FRAME_ERR_O
);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif

    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(UART_DATA_BITS);
    // Start is judged half a bit in; every later bit is one full bit after the previous decision.
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLING / 2 - 1 + VOTE_DLY);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] DBIT_LAST  = BW'(UART_DATA_BITS - 1);

    logic                        tick;
    logic [UART_SYNC_STAGES-1:0] sync_reg;
    logic                        rx_s;
    logic                        rx_prev_reg;
    logic                        fall;
    logic                        bit_val;

    rx_state_t                   state_reg;
    logic [CW-1:0]               tick_cnt_reg;
    logic [BW-1:0]               bit_cnt_reg;
    logic [UART_DATA_BITS-1:0]   shift_reg;
    logic [UART_DATA_BITS-1:0]   data_reg;
    logic                        done_reg;
    logic                        err_reg;

    uart_baudgen #(
        .CLK_RATE     (CLK_RATE),
        .BAUD_RATE    (BAUD_RATE),
        .OVERSAMPLING (OVERSAMPLING)
    ) u_baudgen (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .TICK_O (tick)
    );

    // Synchronizer flops come out of reset high so an idle line never looks like an edge.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[UART_SYNC_STAGES-2:0], RX_I};
            rx_prev_reg <= rx_s;
        end
    end

    assign rx_s = sync_reg[UART_SYNC_STAGES-1];
    assign fall = rx_prev_reg & ~rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Holds rx_s from the two previous ticks; with the current value these form the vote.
    logic [1:0] hist_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            hist_reg <= 2'b11;
        end else if (tick) begin
            hist_reg <= {hist_reg[0], rx_s};
        end
    end

    assign bit_val = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        state_reg    <= START;
                        tick_cnt_reg <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt_reg == START_LAST) begin
                            if (!bit_val) begin
                                state_reg    <= DATA;
                                tick_cnt_reg <= '0;
                                bit_cnt_reg  <= '0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt_reg == BIT_LAST) begin
                            shift_reg[bit_cnt_reg] <= bit_val;
                            tick_cnt_reg           <= '0;
                            if (bit_cnt_reg == DBIT_LAST) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt_reg == BIT_LAST) begin
                            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                            if (bit_val) begin
                                data_reg <= shift_reg;
                                done_reg <= 1'b1;
                            end else begin
                                err_reg <= 1'b1;
                            end
                            tick_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign DATA_O         = data_reg;
    assign RX_DONE_O      = done_reg;
    assign RX_FRAME_ERR_O = err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner cases and random frames
// checked against a frame-level reference model. One bit = 16 clocks.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_o;
    logic       done_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    uart_rx #(
        .CLK_RATE     (1_600_000),
        .BAUD_RATE    (100_000),
        .OVERSAMPLING (16)
    ) dut (
        .CLK_I          (clk),
        .RST_I          (rst),
        .RX_I           (rx),
        .DATA_O         (data_o),
        .RX_DONE_O      (done_o),
        .RX_FRAME_ERR_O (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every high cycle counts, so a stretched strobe shows up as an extra pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (done_o && err_o) both_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         low_after;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Holds the line at v for n clocks; entered and left 1 ns after a rising edge.
    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) line(d[i], 16);
        line(stop, 16);
    endtask

    task automatic check_frame(input string tag, input int d0, input int e0,
                               input int exp_done, input int exp_err, input logic [7:0] exp_data);
        chk({tag, "_done"}, done_cnt - d0, exp_done);
        chk({tag, "_err"}, err_cnt - e0, exp_err);
        chk({tag, "_data"}, int'(data_o), int'(exp_data));
        $display("%s: done=%0d err=%0d DATA_O=%02h", tag, done_cnt - d0, err_cnt - e0, data_o);
    endtask

    initial begin
        int          d0;
        int          e0;
        logic [7:0]  model_data;
        logic [7:0]  rd;
        logic        rs;
        logic        prev_bad;
        logic [7:0]  spike_exp;
        logic [7:0]  b7e;
        int          gap;

        vecs[0] = '{8'hA5, 1'b1, 4, 0, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0, 0, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 0, 0, 1, 0, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 0, 40, 0, 1, 8'h3C};
        vecs[5] = '{8'h81, 1'b1, 5, 0, 1, 0, 8'h81};

        rx  = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_data", int'(data_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_err", int'(err_o), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        line(1'b1, 10);

        // Table: single frame, back-to-back frames, framing error with a long low line.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].gap > 0) line(1'b1, vecs[v].gap);
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            if (vecs[v].low_after > 0) line(1'b0, vecs[v].low_after);
            check_frame($sformatf("vec%0d_%02h", v, vecs[v].data), d0, e0,
                        vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_data);
        end

        // Short low glitch on an idle line must be rejected, then a real frame still lands.
        line(1'b1, 10);
        d0 = done_cnt;
        e0 = err_cnt;
        line(1'b0, 4);
        line(1'b1, 30);
        check_frame("glitch", d0, e0, 0, 0, 8'h81);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 1'b1);
        check_frame("after_glitch_81", d0, e0, 1, 0, 8'h81);

        // Asynchronous reset in the middle of the data bits of 0x7E.
        line(1'b1, 6);
        d0 = done_cnt;
        e0 = err_cnt;
        b7e = 8'h7E;
        line(1'b0, 16);
        for (int i = 0; i < 4; i++) line(b7e[i], 16);
        rx = b7e[4];
        #2 rst = 1'b1;
        #1;
        chk("midreset_data", int'(data_o), 0);
        chk("midreset_done", int'(done_o), 0);
        chk("midreset_err", int'(err_o), 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        line(1'b1, 200);
        check_frame("after_reset", d0, e0, 0, 0, 8'h00);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h12, 1'b1);
        check_frame("after_reset_12", d0, e0, 1, 0, 8'h12);

        // One-clock low spike at the centre of data bit 3 of 0xFF.
`ifdef UART_RX_MAJORITY_VOTE_EN
        spike_exp = 8'hFF;
`else
        spike_exp = 8'hF7;
`endif
        line(1'b1, 5);
        d0 = done_cnt;
        e0 = err_cnt;
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                line(1'b1, 8);
                line(1'b0, 1);
                line(1'b1, 7);
            end else begin
                line(1'b1, 16);
            end
        end
        line(1'b1, 16);
        check_frame("spike_bit3", d0, e0, 1, 0, spike_exp);

        // Random frames against the frame-level model: good stop updates, bad stop keeps.
        model_data = spike_exp;
        prev_bad   = 1'b0;
        for (int n = 0; n < 30; n++) begin
            rd  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 3) != 0);
            gap = prev_bad ? int'($urandom_range(1, 6)) : int'($urandom_range(0, 6));
            if (gap > 0) line(1'b1, gap);
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(rd, rs);
            if (rs) model_data = rd;
            check_frame($sformatf("rand%0d_%02h_s%0d_g%0d", n, rd, rs, gap), d0, e0,
                        rs ? 1 : 0, rs ? 0 : 1, model_data);
            prev_bad = ~rs;
        end
        line(1'b1, 20);

        chk("done_err_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
